serial_frame_rx: RTL and testbench

Serial-to-parallel frame receiver that consumes the registered single-bit stream produced by the D flip-flop stage (its `Q` output drives `Din` here). It detects a start bit and shifts in a fixed-width data word MSB-first. It optionally checks even parity, validates a stop bit, and presents the word on a parallel bus with a one-cycle `Valid` strobe. Bits are sampled once per `Clock` rising edge; there is no oversampling.

---
 rtl/serial_frame_rx_if.sv | 27 ++
 rtl/serial_frame_rx.sv | 93 +++++++++
 tb/tb_serial_frame_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Parallel-side bundle of the serial frame receiver: serial bit in, word/strobes out.
// The master drives Din and watches the results; the receiver is the slave.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             Din;
    logic [WIDTH-1:0] Dout;
    logic             Valid;
    logic             FrameErr;
    logic             Busy;

    modport master (
        output Din,
        input  Dout,
        input  Valid,
        input  FrameErr,
        input  Busy
    );

    modport slave (
        input  Din,
        output Dout,
        output Valid,
        output FrameErr,
        output Busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Receives one start bit, WIDTH data bits MSB-first, an optional even-parity bit and a
// zero stop bit, one bit per Clock edge. Good words go to Dout with a one-cycle Valid.
module serial_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    serial_frame_rx_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             par_reg;
    logic             par_ok_reg;
    logic             valid_reg;
    logic             frame_err_reg;
    logic             busy_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sr_reg        <= '0;
            dout_reg      <= '0;
            par_reg       <= 1'b0;
            par_ok_reg    <= 1'b0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // Strobes are single-cycle: only the STOP branch can raise them.
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.Din) begin
                        state_reg <= SHIFT;
                        cnt_reg   <= '0;
                        sr_reg    <= '0;
                        par_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr_reg  <= {sr_reg[WIDTH-2:0], bus.Din};
                    par_reg <= par_reg ^ bus.Din;
                    // Counter saturates at the last data bit instead of wrapping.
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= PARITY_EN ? PARITY : STOP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                PARITY: begin
                    par_ok_reg <= ~(par_reg ^ bus.Din);
                    state_reg  <= STOP;
                end
                STOP: begin
                    // A 1 here is a framing error, never a new start bit.
                    if (!bus.Din && (!PARITY_EN || par_ok_reg)) begin
                        dout_reg  <= sr_reg;
                        valid_reg <= 1'b1;
                    end else begin
                        frame_err_reg <= 1'b1;
                    end
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Dout     = dout_reg;
    assign bus.Valid    = valid_reg;
    assign bus.FrameErr = frame_err_reg;
    assign bus.Busy     = busy_reg;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: one receiver without parity, one with even parity.
module tb_serial_frame_rx;
    logic Clock;
    logic Reset;

    serial_frame_rx_if #(.WIDTH(8)) if0 ();
    serial_frame_rx_if #(.WIDTH(8)) if1 ();

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0)) dut0 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if0)
    );

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int busy_cnt = 0;
    int spurious = 0;
    int valid_edge_a;
    int valid_edge_b;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one bit to the selected receiver (the other sees 0), then sample 1 ns after the edge.
    task automatic send_bit(input int which, input bit b);
        if0.Din = (which == 0) ? b : 1'b0;
        if1.Din = (which == 1) ? b : 1'b0;
        @(posedge Clock);
        #1;
        edge_n++;
    endtask

    // Full frame; counts Busy-high cycles and any strobe seen before the stop edge.
    task automatic frame(input int which, input logic [7:0] data, input bit has_par,
                         input bit par, input bit stop);
        logic busy_s, strobe_s;
        busy_cnt = 0;
        for (int i = 0; i < 10 + int'(has_par); i++) begin
            bit b;
            if (i == 0) b = 1'b1;
            else if (i <= 8) b = data[8-i];
            else if (has_par && i == 9) b = par;
            else b = stop;
            send_bit(which, b);
            busy_s   = (which == 0) ? if0.Busy : if1.Busy;
            strobe_s = (which == 0) ? (if0.Valid | if0.FrameErr) : (if1.Valid | if1.FrameErr);
            if (busy_s) busy_cnt++;
            if (i < 9 + int'(has_par) && strobe_s) spurious++;
        end
        $display("frame dut%0d data %02h par %0d stop %0d -> Dout %02h Valid %0d FrameErr %0d",
                 which, data, par, stop,
                 (which == 0) ? if0.Dout : if1.Dout,
                 (which == 0) ? if0.Valid : if1.Valid,
                 (which == 0) ? if0.FrameErr : if1.FrameErr);
    endtask

    initial begin
        Reset  = 1'b1;
        if0.Din = 1'b0;
        if1.Din = 1'b0;
        #12;
        check("reset_dout", 32'(if0.Dout), 32'h0);
        check("reset_valid", 32'(if0.Valid), 32'h0);
        check("reset_ferr", 32'(if0.FrameErr), 32'h0);
        check("reset_busy", 32'(if0.Busy), 32'h0);
        Reset = 1'b0;

        // Idle line keeps the FSM in IDLE.
        for (int i = 0; i < 5; i++) begin
            send_bit(0, 1'b0);
            check("idle_busy", 32'(if0.Busy), 32'h0);
        end

        // Stop-bit failure straight after reset.
        frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("stopfail_ferr", 32'(if0.FrameErr), 32'h1);
        check("stopfail_valid", 32'(if0.Valid), 32'h0);
        check("stopfail_dout", 32'(if0.Dout), 32'h0);
        check("stopfail_busy", 32'(if0.Busy), 32'h0);
        send_bit(0, 1'b0);
        check("stopfail_ferr_pulse", 32'(if0.FrameErr), 32'h0);
        check("stopfail_idle", 32'(if0.Busy), 32'h0);

        // Good frame 0xA5.
        frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("good_valid", 32'(if0.Valid), 32'h1);
        check("good_ferr", 32'(if0.FrameErr), 32'h0);
        check("good_dout", 32'(if0.Dout), 32'hA5);
        check("good_busy_cycles", 32'(busy_cnt), 32'd9);
        send_bit(0, 1'b0);
        check("good_valid_pulse", 32'(if0.Valid), 32'h0);
        check("good_dout_hold", 32'(if0.Dout), 32'hA5);

        // Even parity on the second receiver.
        frame(1, 8'h3C, 1'b1, 1'b0, 1'b0);
        check("par_ok_valid", 32'(if1.Valid), 32'h1);
        check("par_ok_dout", 32'(if1.Dout), 32'h3C);
        check("par_busy_cycles", 32'(busy_cnt), 32'd10);
        send_bit(1, 1'b0);
        frame(1, 8'h3C, 1'b1, 1'b1, 1'b0);
        check("par_bad_ferr", 32'(if1.FrameErr), 32'h1);
        check("par_bad_valid", 32'(if1.Valid), 32'h0);
        check("par_bad_dout", 32'(if1.Dout), 32'h3C);
        send_bit(1, 1'b0);
        frame(1, 8'h3D, 1'b1, 1'b1, 1'b0);
        check("par_odd_valid", 32'(if1.Valid), 32'h1);
        check("par_odd_dout", 32'(if1.Dout), 32'h3D);
        send_bit(1, 1'b0);

        // Back-to-back frames with no idle bit.
        frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
        valid_edge_a = edge_n;
        check("b2b_first_valid", 32'(if0.Valid), 32'h1);
        check("b2b_first_dout", 32'(if0.Dout), 32'h81);
        frame(0, 8'h7E, 1'b0, 1'b0, 1'b0);
        valid_edge_b = edge_n;
        check("b2b_second_valid", 32'(if0.Valid), 32'h1);
        check("b2b_second_dout", 32'(if0.Dout), 32'h7E);
        check("b2b_spacing", 32'(valid_edge_b - valid_edge_a), 32'd10);
        send_bit(0, 1'b0);

        // Reset after the 4th data bit of 0xFF.
        send_bit(0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        check("midrst_busy_before", 32'(if0.Busy), 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_busy_now", 32'(if0.Busy), 32'h0);
        check("midrst_dout_now", 32'(if0.Dout), 32'h0);
        if0.Din = 1'b0;
        #2;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_bit(0, 1'b0);
            check("midrst_no_strobe", 32'(if0.Valid | if0.FrameErr), 32'h0);
            check("midrst_idle", 32'(if0.Busy), 32'h0);
        end
        frame(0, 8'h12, 1'b0, 1'b0, 1'b0);
        check("midrst_valid", 32'(if0.Valid), 32'h1);
        check("midrst_dout", 32'(if0.Dout), 32'h12);
        send_bit(0, 1'b0);

        check("no_early_strobes", 32'(spurious), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
